// File: rtl/zilla_pkg.sv
// Shared constants and FSM encoding for the zilla branch resolve unit.
// Latency: none (package only).
// Backpressure: n/a.
package zilla_pkg;

   // Major opcodes that the resolve unit reacts to
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;

   // Conditional-branch func3 encodings
   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;
   localparam logic [2:0] F3_JALR = 3'b000;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_REDIRECT = 2'd1,
      ST_FLUSH    = 2'd2
   } br_state_t;

   // True for func3 codes that name a real conditional branch
   function automatic logic is_cond_f3(input logic [2:0] f3);
      return (f3 != 3'b010) && (f3 != 3'b011);
   endfunction

endpackage

// File: rtl/zilla_branch_resolve_unit_if.sv
// Decode-side bundle of the branch resolve unit (operands, fields, redirect outputs).
// Latency: none (wiring only); stats ports exist only with ZILLA_BR_STATS_EN.
// Backpressure: stall_en blocks branch acceptance; no ready on the redirect side.
interface zilla_branch_resolve_unit_if #(
   parameter int DATA_WIDTH     = 32,
   parameter int PC_WIDTH       = 20,
   parameter int GPR_ADDR_WIDTH = 5,
   parameter int FWD_DEPTH      = 3
);
   logic                            stall_en;
   logic                            br_valid_i;
   logic [6:0]                      opcode;
   logic [2:0]                      func3;
   logic [DATA_WIDTH-1:0]           rs1_data;
   logic [DATA_WIDTH-1:0]           rs2_data;
   logic [GPR_ADDR_WIDTH-1:0]       id_ex_rs1;
   logic [GPR_ADDR_WIDTH-1:0]       id_ex_rs2;
   logic [GPR_ADDR_WIDTH-1:0]       id_ex_rd;
   logic                            id_ex_reg_wr_en;
   logic [FWD_DEPTH*DATA_WIDTH-1:0] fwd_data_i;
   logic [DATA_WIDTH-1:0]           imm_val;
   logic [PC_WIDTH-1:0]             pc;
   logic                            branch_en;
   logic [PC_WIDTH-1:0]             branch_pc;
   logic                            flush_o;
   logic                            misalign_o;
   logic                            busy_o;
`ifdef ZILLA_BR_STATS_EN
   logic [31:0]                     br_cnt_o;
   logic [31:0]                     taken_cnt_o;
`endif

   modport master (
`ifdef ZILLA_BR_STATS_EN
      input  br_cnt_o, taken_cnt_o,
`endif
      output stall_en, br_valid_i, opcode, func3, rs1_data, rs2_data,
      output id_ex_rs1, id_ex_rs2, id_ex_rd, id_ex_reg_wr_en, fwd_data_i,
      output imm_val, pc,
      input  branch_en, branch_pc, flush_o, misalign_o, busy_o
   );

   modport slave (
`ifdef ZILLA_BR_STATS_EN
      output br_cnt_o, taken_cnt_o,
`endif
      input  stall_en, br_valid_i, opcode, func3, rs1_data, rs2_data,
      input  id_ex_rs1, id_ex_rs2, id_ex_rd, id_ex_reg_wr_en, fwd_data_i,
      input  imm_val, pc,
      output branch_en, branch_pc, flush_o, misalign_o, busy_o
   );
endinterface

// File: rtl/zilla_br_compare.sv
// Conditional-branch comparator: evaluates func3 condition on two operands.
// Latency: combinational.
// Backpressure: none.
module zilla_br_compare
   import zilla_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic [DATA_WIDTH-1:0] oper1,
   input  logic [DATA_WIDTH-1:0] oper2,
   input  logic [2:0]            func3,
   output logic                  taken
);

   logic w_eq;
   logic w_lt_s;
   logic w_lt_u;

   assign w_eq   = (oper1 == oper2);
   assign w_lt_s = ($signed(oper1) < $signed(oper2));
   assign w_lt_u = (oper1 < oper2);

   // Select the condition named by func3; reserved codes never take
   always_comb begin
      taken = 1'b0;
      case (func3)
         F3_BEQ:  taken = w_eq;
         F3_BNE:  taken = !w_eq;
         F3_BLT:  taken = w_lt_s;
         F3_BGE:  taken = !w_lt_s;
         F3_BLTU: taken = w_lt_u;
         F3_BGEU: taken = !w_lt_u;
         default: taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/zilla_branch_resolve_unit.sv
// Branch resolve: forwards operands, decides taken, issues redirect then flushes fetch/decode.
// Latency: decode to branch_en 1 cycle; FLUSH_CYCLES of flush_o plus one settle cycle in FLUSH.
// Backpressure: stall_en blocks acceptance only; ZILLA_BR_STATS_EN adds br_cnt_o/taken_cnt_o.
module zilla_branch_resolve_unit
   import zilla_pkg::*;
#(
   parameter int DATA_WIDTH     = 32,
   parameter int PC_WIDTH       = 20,
   parameter int GPR_ADDR_WIDTH = 5,
   parameter int FWD_DEPTH      = 3,
   parameter int PC_OFFSET      = 8,
   parameter int FLUSH_CYCLES   = 2
) (
   input  logic                        br_clk,
   input  logic                        br_rst,
   zilla_branch_resolve_unit_if.slave  bus
);

   localparam logic [PC_WIDTH-1:0] PC_OFF = PC_WIDTH'(PC_OFFSET);
   localparam logic [2:0]          FC     = 3'(FLUSH_CYCLES);

   // Writer history of the instructions ahead of decode; index 0 is the nearest stage
   logic [GPR_ADDR_WIDTH-1:0] r_rd [FWD_DEPTH];
   logic                      r_wr [FWD_DEPTH];

   br_state_t           r_state;
   logic [2:0]          r_cnt;
   logic                r_branch_en;
   logic [PC_WIDTH-1:0] r_branch_pc;
   logic                r_flush;
   logic                r_misalign;
   logic                r_busy;

   logic [DATA_WIDTH-1:0] w_oper1;
   logic [DATA_WIDTH-1:0] w_oper2;
   logic                  w_cmp_taken;
   logic                  w_is_cond;
   logic                  w_is_jal;
   logic                  w_is_jalr;
   logic                  w_taken;
   logic                  w_eval;
   logic                  w_accept;
   logic [PC_WIDTH-1:0]   w_target;
   logic                  w_unused;

   // Upper immediate bits do not reach the PC-width target
   assign w_unused = &{1'b0, bus.imm_val};

   // Shift the decode-stage writer info down the history every cycle, even when stalled
   always_ff @(posedge br_clk or posedge br_rst) begin
      if (br_rst) begin
         for (int k = 0; k < FWD_DEPTH; k++) begin
            r_rd[k] <= '0;
            r_wr[k] <= 1'b0;
         end
      end else begin
         r_rd[0] <= bus.id_ex_rd;
         r_wr[0] <= bus.id_ex_reg_wr_en;
         for (int k = 1; k < FWD_DEPTH; k++) begin
            r_rd[k] <= r_rd[k-1];
            r_wr[k] <= r_wr[k-1];
         end
      end
   end

   // Operand select: scan far-to-near so the nearest matching writer wins; x0 never forwards
   always_comb begin
      w_oper1 = bus.rs1_data;
      w_oper2 = bus.rs2_data;
      for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
         if (r_wr[k] && (r_rd[k] != '0) && (r_rd[k] == bus.id_ex_rs1))
            w_oper1 = bus.fwd_data_i[k*DATA_WIDTH +: DATA_WIDTH];
         if (r_wr[k] && (r_rd[k] != '0) && (r_rd[k] == bus.id_ex_rs2))
            w_oper2 = bus.fwd_data_i[k*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   zilla_br_compare #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_cmp (
      .oper1 (w_oper1),
      .oper2 (w_oper2),
      .func3 (bus.func3),
      .taken (w_cmp_taken)
   );

   assign w_is_cond = (bus.opcode == OPC_BRANCH) && is_cond_f3(bus.func3);
   assign w_is_jal  = (bus.opcode == OPC_JAL);
   assign w_is_jalr = (bus.opcode == OPC_JALR) && (bus.func3 == F3_JALR);
   assign w_taken   = (w_is_cond && w_cmp_taken) || w_is_jal || w_is_jalr;
   assign w_eval    = bus.br_valid_i && !bus.stall_en && (r_state == ST_IDLE);
   assign w_accept  = w_eval && w_taken;

   // Target: pc-relative for branch/JAL, register-relative with bit0 cleared for JALR
   always_comb begin
      w_target = (bus.pc - PC_OFF) + bus.imm_val[PC_WIDTH-1:0];
      if (w_is_jalr) begin
         w_target    = w_oper1[PC_WIDTH-1:0] + bus.imm_val[PC_WIDTH-1:0];
         w_target[0] = 1'b0;
      end
   end

   // Redirect/flush FSM; the last FLUSH cycle drops flush_o but stays busy to space redirects
   always_ff @(posedge br_clk or posedge br_rst) begin
      if (br_rst) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_branch_en <= 1'b0;
         r_branch_pc <= '0;
         r_flush     <= 1'b0;
         r_misalign  <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_branch_en <= 1'b0;
         r_misalign  <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_busy  <= 1'b1;
                  r_flush <= 1'b1;
                  r_cnt   <= '0;
                  if (w_target[1]) begin
                     r_state    <= ST_FLUSH;
                     r_misalign <= 1'b1;
                  end else begin
                     r_state     <= ST_REDIRECT;
                     r_branch_en <= 1'b1;
                     r_branch_pc <= w_target;
                  end
               end
            end
            ST_REDIRECT: begin
               r_state <= ST_FLUSH;
               r_cnt   <= '0;
            end
            ST_FLUSH: begin
               if (r_cnt == FC) begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
                  r_flush <= 1'b0;
               end else begin
                  r_cnt   <= r_cnt + 3'd1;
                  r_flush <= ((r_cnt + 3'd1) < FC);
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
               r_flush <= 1'b0;
            end
         endcase
      end
   end

   assign bus.branch_en  = r_branch_en;
   assign bus.branch_pc  = r_branch_pc;
   assign bus.flush_o    = r_flush;
   assign bus.misalign_o = r_misalign;
   assign bus.busy_o     = r_busy;

`ifdef ZILLA_BR_STATS_EN
   logic [31:0] r_br_cnt;
   logic [31:0] r_taken_cnt;

   // Saturating counters: evaluated conditional branches and issued redirects
   always_ff @(posedge br_clk or posedge br_rst) begin
      if (br_rst) begin
         r_br_cnt    <= '0;
         r_taken_cnt <= '0;
      end else begin
         if (w_eval && w_is_cond && (r_br_cnt != '1))
            r_br_cnt <= r_br_cnt + 32'd1;
         if (w_accept && !w_target[1] && (r_taken_cnt != '1))
            r_taken_cnt <= r_taken_cnt + 32'd1;
      end
   end

   assign bus.br_cnt_o    = r_br_cnt;
   assign bus.taken_cnt_o = r_taken_cnt;
`endif

endmodule

// File: tb/tb_zilla_branch_resolve_unit.sv
// Directed bench for zilla_branch_resolve_unit with hand-computed expectations.
// Latency: checks 1-cycle redirect, flush/busy lengths, async reset.
// Backpressure: exercises stall_en and busy-window rejection.
module tb_zilla_branch_resolve_unit;
   import zilla_pkg::*;

   logic br_clk = 1'b0;
   logic br_rst = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;

   zilla_branch_resolve_unit_if #(
      .DATA_WIDTH(32), .PC_WIDTH(20), .GPR_ADDR_WIDTH(5), .FWD_DEPTH(3)
   ) bus ();

   zilla_branch_resolve_unit #(
      .DATA_WIDTH(32), .PC_WIDTH(20), .GPR_ADDR_WIDTH(5), .FWD_DEPTH(3),
      .PC_OFFSET(8), .FLUSH_CYCLES(2)
   ) dut (
      .br_clk (br_clk),
      .br_rst (br_rst),
      .bus    (bus)
   );

   always #5 br_clk = ~br_clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge br_clk);
      #1;
   endtask

   task automatic clear_inputs();
      bus.stall_en        = 1'b0;
      bus.br_valid_i      = 1'b0;
      bus.opcode          = 7'd0;
      bus.func3           = 3'd0;
      bus.rs1_data        = '0;
      bus.rs2_data        = '0;
      bus.id_ex_rs1       = '0;
      bus.id_ex_rs2       = '0;
      bus.id_ex_rd        = '0;
      bus.id_ex_reg_wr_en = 1'b0;
      bus.fwd_data_i      = '0;
      bus.imm_val         = '0;
      bus.pc              = '0;
   endtask

   task automatic present(input logic [6:0] op, input logic [2:0] f3,
                          input logic [31:0] d1, input logic [31:0] d2,
                          input logic [31:0] imm, input logic [19:0] pcv);
      bus.br_valid_i = 1'b1;
      bus.opcode     = op;
      bus.func3      = f3;
      bus.rs1_data   = d1;
      bus.rs2_data   = d2;
      bus.id_ex_rs1  = 5'd1;
      bus.id_ex_rs2  = 5'd2;
      bus.imm_val    = imm;
      bus.pc         = pcv;
   endtask

   // Observe 10 cycles after a presented instruction; valid drops after the first edge
   task automatic watch(output logic be1, output logic mis1, output int n_be,
                        output int n_fl, output int n_busy, output int n_mis,
                        output logic [19:0] pc_be);
      be1 = 1'b0; mis1 = 1'b0; n_be = 0; n_fl = 0; n_busy = 0; n_mis = 0; pc_be = '0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (i == 0) begin
            bus.br_valid_i = 1'b0;
            be1  = bus.branch_en;
            mis1 = bus.misalign_o;
         end
         if (bus.branch_en) begin
            n_be++;
            pc_be = bus.branch_pc;
         end
         if (bus.flush_o)    n_fl++;
         if (bus.busy_o)     n_busy++;
         if (bus.misalign_o) n_mis++;
      end
   endtask

   task automatic preload(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c);
      bus.id_ex_reg_wr_en = 1'b1;
      bus.id_ex_rd = a; step();
      bus.id_ex_rd = b; step();
      bus.id_ex_rd = c; step();
      bus.id_ex_reg_wr_en = 1'b0;
      bus.id_ex_rd = '0;
   endtask

   logic        be1, mis1;
   int          n_be, n_fl, n_busy, n_mis;
   logic [19:0] pc_be;

   initial begin
      clear_inputs();
      step();
      step();
      chk("rst_branch_en", bus.branch_en, 0);
      chk("rst_branch_pc", bus.branch_pc, 0);
      chk("rst_flush", bus.flush_o, 0);
      chk("rst_misalign", bus.misalign_o, 0);
      chk("rst_busy", bus.busy_o, 0);
      br_rst = 1'b0;
      step();

      // BEQ 5==5, target (0x108-8)+0x10
      present(OPC_BRANCH, F3_BEQ, 32'd5, 32'd5, 32'h10, 20'h108);
      watch(be1, mis1, n_be, n_fl, n_busy, n_mis, pc_be);
      chk("beq_latency", be1, 1);
      chk("beq_pc", pc_be, 20'h110);
      chk("beq_pulses", n_be, 1);
      chk("beq_flush_len", n_fl, 3);
      chk("beq_busy_len", n_busy, 4);

      // Signed vs unsigned compare of -1 and 1
      present(OPC_BRANCH, F3_BLT, 32'hFFFF_FFFF, 32'd1, 32'h40, 20'h200);
      watch(be1, mis1, n_be, n_fl, n_busy, n_mis, pc_be);
      chk("blt_taken", be1, 1);
      chk("blt_pc", pc_be, 20'h238);
      present(OPC_BRANCH, F3_BLTU, 32'hFFFF_FFFF, 32'd1, 32'h40, 20'h200);
      watch(be1, mis1, n_be, n_fl, n_busy, n_mis, pc_be);
      chk("bltu_not_taken", n_be, 0);
      chk("bltu_no_flush", n_fl, 0);
      chk("bltu_no_busy", n_busy, 0);

      // Forwarding: rd=3 at k=0 (7) and k=2 (9), nearest must win
      preload(5'd3, 5'd5, 5'd3);
      present(OPC_BRANCH, F3_BEQ, 32'd0, 32'd7, 32'h20, 20'h300);
      bus.id_ex_rs1  = 5'd3;
      bus.id_ex_rs2  = 5'd4;
      bus.fwd_data_i = {32'd9, 32'd11, 32'd7};
      watch(be1, mis1, n_be, n_fl, n_busy, n_mis, pc_be);
      chk("fwd_near_taken", be1, 1);
      chk("fwd_pc", pc_be, 20'h318);
      preload(5'd0, 5'd0, 5'd0);
      present(OPC_BRANCH, F3_BEQ, 32'd0, 32'd7, 32'h20, 20'h300);
      bus.id_ex_rs1  = 5'd0;
      bus.id_ex_rs2  = 5'd4;
      bus.fwd_data_i = {32'd7, 32'd7, 32'd7};
      watch(be1, mis1, n_be, n_fl, n_busy, n_mis, pc_be);
      chk("fwd_x0_not_taken", n_be, 0);
      bus.fwd_data_i = '0;

      // JALR alignment handling
      present(OPC_JALR, F3_JALR, 32'h1001, 32'd0, 32'd0, 20'h0);
      watch(be1, mis1, n_be, n_fl, n_busy, n_mis, pc_be);
      chk("jalr_taken", be1, 1);
      chk("jalr_pc", pc_be, 20'h1000);
      present(OPC_JALR, F3_JALR, 32'h1002, 32'd0, 32'd0, 20'h0);
      watch(be1, mis1, n_be, n_fl, n_busy, n_mis, pc_be);
      chk("mis_pulse_first", mis1, 1);
      chk("mis_pulse_count", n_mis, 1);
      chk("mis_no_branch_en", n_be, 0);
      chk("mis_flush_len", n_fl, 2);
      chk("mis_busy_len", n_busy, 3);

      // Back-to-back taken branches: second lands in REDIRECT and is ignored
      present(OPC_BRANCH, F3_BEQ, 32'd1, 32'd1, 32'h10, 20'h400);
      step();
      chk("b2b_first_en", bus.branch_en, 1);
      chk("b2b_first_pc", bus.branch_pc, 20'h408);
      bus.pc = 20'h500;
      step();
      bus.br_valid_i = 1'b0;
      chk("b2b_second_en", bus.branch_en, 0);
      chk("b2b_flushing", bus.flush_o, 1);
      n_be = 0;
      for (int i = 0; i < 8; i++) begin
         step();
         if (bus.branch_en) n_be++;
      end
      chk("b2b_no_extra", n_be, 0);

      // Stalled taken branch is not accepted
      present(OPC_BRANCH, F3_BEQ, 32'd1, 32'd1, 32'h10, 20'h400);
      bus.stall_en = 1'b1;
      step();
      chk("stall_no_en", bus.branch_en, 0);
      chk("stall_no_busy", bus.busy_o, 0);
      clear_inputs();
      step();

`ifdef ZILLA_BR_STATS_EN
      chk("stats_br_cnt", bus.br_cnt_o, 6);
      chk("stats_taken_cnt", bus.taken_cnt_o, 5);
`endif

      // Asynchronous reset during FLUSH
      present(OPC_BRANCH, F3_BEQ, 32'd2, 32'd2, 32'h10, 20'h600);
      step();
      bus.br_valid_i = 1'b0;
      step();
      chk("pre_rst_busy", bus.busy_o, 1);
      #2;
      br_rst = 1'b1;
      #1;
      chk("arst_branch_en", bus.branch_en, 0);
      chk("arst_branch_pc", bus.branch_pc, 0);
      chk("arst_flush", bus.flush_o, 0);
      chk("arst_misalign", bus.misalign_o, 0);
      chk("arst_busy", bus.busy_o, 0);
      step();
      br_rst = 1'b0;
      step();
      chk("post_rst_busy", bus.busy_o, 0);
      present(OPC_BRANCH, F3_BEQ, 32'd3, 32'd3, 32'h20, 20'h700);
      watch(be1, mis1, n_be, n_fl, n_busy, n_mis, pc_be);
      chk("post_rst_redirect", be1, 1);
      chk("post_rst_pc", pc_be, 20'h718);
`ifdef ZILLA_BR_STATS_EN
      chk("stats_post_rst_br", bus.br_cnt_o, 1);
      chk("stats_post_rst_taken", bus.taken_cnt_o, 1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
